// File: rtl/fpga_slave.sv
// ARM-facing slave port: serial read-out of a held FPGA word, plus nibble-assembled ARM writes.
// Optional macro FPGA_SLAVE_PARITY_EN appends an even-parity bit to every read frame.
`timescale 1ns/1ps
module fpga_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int IN_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_enable,
    input  logic [3:0]      from_ARM,
    output logic            to_ARM,
    output logic            out_enable,
    output logic [7:0]      out_data,
    output logic            dirty
);

`ifdef FPGA_SLAVE_PARITY_EN
    localparam int FRAME_W = IN_W + 1;
`else
    localparam int FRAME_W = IN_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W);

    localparam logic [3:0] CMD_WRITE = 4'b0110;
    localparam logic [3:0] CMD_READ  = 4'b0001;

    typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, RD_SHIFT} state_t;

    logic [SYNC_STAGES-1:0]      sclk_sync_q;
    logic                        sclk_prev_q;
    logic [SYNC_STAGES-1:0][3:0] arm_sync_q;

    state_t             state_q,      state_d;
    logic [IN_W-1:0]    hold_q,       hold_d;
    logic [FRAME_W-2:0] shift_q,      shift_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               to_arm_q,     to_arm_d;
    logic [3:0]         hi_q,         hi_d;
    logic [7:0]         out_data_q,   out_data_d;
    logic               out_enable_q, out_enable_d;
    logic               dirty_q,      dirty_d;
    logic               reload_q,     reload_d;

    logic               sclk_s;
    logic               rise;
    logic               fall;
    logic [3:0]         nibble;
    logic [FRAME_W-1:0] frame_load;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev_q;
    assign fall   = ~sclk_s & sclk_prev_q;
    assign nibble = arm_sync_q[SYNC_STAGES-1];

`ifdef FPGA_SLAVE_PARITY_EN
    assign frame_load = {hold_q, ^hold_q};
`else
    assign frame_load = hold_q;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            arm_sync_q   <= '0;
            state_q      <= IDLE;
            hold_q       <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            to_arm_q     <= 1'b0;
            hi_q         <= '0;
            out_data_q   <= '0;
            out_enable_q <= 1'b0;
            dirty_q      <= 1'b0;
            reload_q     <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sclk_prev_q  <= sclk_s;
            arm_sync_q   <= {arm_sync_q[SYNC_STAGES-2:0], from_ARM};
            state_q      <= state_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            to_arm_q     <= to_arm_d;
            hi_q         <= hi_d;
            out_data_q   <= out_data_d;
            out_enable_q <= out_enable_d;
            dirty_q      <= dirty_d;
            reload_q     <= reload_d;
        end
    end

    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        to_arm_d     = to_arm_q;
        hi_d         = hi_q;
        out_data_d   = out_data_q;
        out_enable_d = 1'b0;
        dirty_d      = dirty_q;
        reload_d     = reload_q;

        if (in_enable) begin
            hold_d  = in_data;
            dirty_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    if (nibble == CMD_WRITE) begin
                        state_d = WR_HI;
                    end else if (nibble == CMD_READ && dirty_q) begin
                        // Frame is built from the pre-load holding value; a same-cycle load marks a reload.
                        shift_d  = frame_load[FRAME_W-2:0];
                        to_arm_d = frame_load[FRAME_W-1];
                        cnt_d    = CNT_W'(FRAME_W - 1);
                        reload_d = in_enable;
                        state_d  = RD_SHIFT;
                    end
                end
            end
            WR_HI: begin
                if (rise) begin
                    hi_d    = nibble;
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                if (rise) begin
                    out_data_d   = {hi_q, nibble};
                    out_enable_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            RD_SHIFT: begin
                if (in_enable) begin
                    reload_d = 1'b1;
                end
                if (fall) begin
                    if (cnt_q != '0) begin
                        to_arm_d = shift_q[FRAME_W-2];
                        shift_d  = shift_q << 1;
                        cnt_d    = cnt_q - 1'b1;
                    end else begin
                        to_arm_d = 1'b0;
                        dirty_d  = in_enable | reload_q;
                        reload_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign to_ARM     = to_arm_q;
    assign out_enable = out_enable_q;
    assign out_data   = out_data_q;
    assign dirty      = dirty_q;

endmodule

// File: tb/tb_fpga_slave.sv
// Directed bench for fpga_slave: reset, read frames, nibble writes, ignored commands, reload and reset aborts.
// Honours FPGA_SLAVE_PARITY_EN by extending each expected frame with its even-parity bit.
`timescale 1ns/1ps
module tb_fpga_slave;

    localparam int SYNC_STAGES = 2;
    localparam int IN_W        = 16;
`ifdef FPGA_SLAVE_PARITY_EN
    localparam int FRAME_W = IN_W + 1;
`else
    localparam int FRAME_W = IN_W;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            sclk;
    logic [IN_W-1:0] in_data;
    logic            in_enable;
    logic [3:0]      from_ARM;
    logic            to_ARM;
    logic            out_enable;
    logic [7:0]      out_data;
    logic            dirty;

    int vectors     = 0;
    int miscompares = 0;
    int oe_count    = 0;

    always #5 clk = ~clk;

    fpga_slave #(.SYNC_STAGES(SYNC_STAGES), .IN_W(IN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .in_data    (in_data),
        .in_enable  (in_enable),
        .from_ARM   (from_ARM),
        .to_ARM     (to_ARM),
        .out_enable (out_enable),
        .out_data   (out_data),
        .dirty      (dirty)
    );

    // Each clk with out_enable high is one count, so a single one-clk strobe adds exactly 1.
    always @(negedge clk) if (out_enable) oe_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [IN_W-1:0] w);
        in_data   = w;
        in_enable = 1'b1;
        idle(1);
        in_enable = 1'b0;
    endtask

    // One sclk pulse carrying nib; to_ARM is sampled late in the high phase. With do_load the
    // in_enable pulse lands in the very clk where the rise is decoded.
    task automatic pulse(input logic [3:0] nib, input bit do_load, input logic [IN_W-1:0] lv,
                         output logic b);
        from_ARM = nib;
        idle(2);
        sclk = 1'b1;
        if (do_load) begin
            idle(SYNC_STAGES);
            in_data   = lv;
            in_enable = 1'b1;
            idle(1);
            in_enable = 1'b0;
            idle(5 - SYNC_STAGES);
        end else begin
            idle(6);
        end
        b    = to_ARM;
        sclk = 1'b0;
        idle(6);
    endtask

    // load_at: -1 none, 0 simultaneous with READ decode, k>0 after the k-th pulse.
    task automatic read_frame(input string tag, input logic [IN_W-1:0] word, input int load_at,
                              input logic [IN_W-1:0] lv);
        logic [FRAME_W-1:0] exp_frame;
        logic b;
`ifdef FPGA_SLAVE_PARITY_EN
        exp_frame = {word, ^word};
`else
        exp_frame = word;
`endif
        for (int k = 0; k < FRAME_W; k++) begin
            // WRITE nibbles during shifting must be ignored.
            pulse(k == 0 ? 4'b0001 : 4'b0110, (k == 0) && (load_at == 0), lv, b);
            check($sformatf("%s bit%0d", tag, k), {31'd0, b}, {31'd0, exp_frame[FRAME_W-1-k]});
            if (k > 0 && k == load_at) load(lv);
        end
    endtask

    task automatic write_byte(input string tag, input logic [3:0] hi, input logic [3:0] lo);
        int oe0;
        logic b;
        oe0 = oe_count;
        pulse(4'b0110, 1'b0, '0, b);
        pulse(hi, 1'b0, '0, b);
        pulse(lo, 1'b0, '0, b);
        idle(2);
        check({tag, " oe pulses"}, oe_count - oe0, 1);
        check({tag, " out_data"}, {24'd0, out_data}, {24'd0, hi, lo});
    endtask

    initial begin
        int   oe0;
        int   lat;
        logic b;

        rst = 1'b1; sclk = 1'b0; in_enable = 1'b0; in_data = '0; from_ARM = '0;
        idle(4);
        check("rst to_ARM", {31'd0, to_ARM}, 0);
        check("rst out_enable", {31'd0, out_enable}, 0);
        check("rst out_data", {24'd0, out_data}, 0);
        check("rst dirty", {31'd0, dirty}, 0);
        rst = 1'b0;
        idle(2);

        load(16'h00F3);
        check("load dirty", {31'd0, dirty}, 1);
        read_frame("f3", 16'h00F3, -1, '0);
        idle(4);
        check("f3 dirty end", {31'd0, dirty}, 0);
        check("f3 to_ARM end", {31'd0, to_ARM}, 0);

        // Write 6,C,1 with the strobe latency measured on the final nibble.
        oe0 = oe_count;
        pulse(4'b0110, 1'b0, '0, b);
        pulse(4'b1100, 1'b0, '0, b);
        from_ARM = 4'b0001;
        idle(2);
        sclk = 1'b1;
        lat  = 0;
        for (int i = 1; i <= 8; i++) begin
            idle(1);
            if (out_enable && lat == 0) lat = i;
        end
        check("wr oe latency", {31'd0, (lat >= SYNC_STAGES + 1 && lat <= SYNC_STAGES + 2)}, 1);
        sclk = 1'b0;
        idle(6);
        check("wr oe pulses", oe_count - oe0, 1);
        check("wr out_data", {24'd0, out_data}, 32'hC1);
        check("wr dirty", {31'd0, dirty}, 0);
        check("wr to_ARM", {31'd0, to_ARM}, 0);

        // READ while clean, then junk nibbles: FSM must stay in IDLE.
        pulse(4'b0001, 1'b0, '0, b);
        check("clean read to_ARM", {31'd0, b}, 0);
        pulse(4'b1111, 1'b0, '0, b);
        pulse(4'b0000, 1'b0, '0, b);
        check("junk to_ARM", {31'd0, b}, 0);
        check("junk out_data held", {24'd0, out_data}, 32'hC1);
        write_byte("idle proof", 4'hA, 4'h5);

        // Reload mid-frame leaves the frame intact and dirty set.
        load(16'hA5A5);
        read_frame("a5", 16'hA5A5, 3, 16'h1234);
        idle(4);
        check("a5 dirty end", {31'd0, dirty}, 1);
        read_frame("12", 16'h1234, -1, '0);
        idle(4);
        check("12 dirty end", {31'd0, dirty}, 0);

        // Load coinciding with READ decode: old word goes out, dirty stays.
        load(16'h8001);
        read_frame("sim", 16'h8001, 0, 16'h7FFE);
        idle(4);
        check("sim dirty end", {31'd0, dirty}, 1);
        read_frame("7f", 16'h7FFE, -1, '0);
        idle(4);
        check("7f dirty end", {31'd0, dirty}, 0);

        // Reset in the middle of a frame.
        load(16'hFFFF);
        pulse(4'b0001, 1'b0, '0, b);
        check("abort bit0", {31'd0, b}, 1);
        pulse(4'b0000, 1'b0, '0, b);
        check("abort bit1", {31'd0, b}, 1);
        rst = 1'b1;
        idle(2);
        check("abort to_ARM", {31'd0, to_ARM}, 0);
        check("abort dirty", {31'd0, dirty}, 0);
        check("abort out_data", {24'd0, out_data}, 0);
        rst = 1'b0;
        idle(2);
        write_byte("post abort", 4'h3, 4'hC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
